// File: rtl/placement_seq_ctrl.sv
// placement_seq_ctrl: phase-strobe sequencer for the 8-stage rectangle-placement pipeline,
// with valid/ready admission, token tracking, RAM enable gating and occupancy-clear sweep.
module placement_seq_ctrl #(
    parameter int NUM_STRIPS = 16,
    parameter int ADDR_W     = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              clear_i,
    output logic [3:0]        phase_en_o,
    output logic              ram_rd_en_o,
    output logic              ram_wr_en_o,
    output logic              clr_active_o,
    output logic [ADDR_W-1:0] clr_addr_o,
    output logic              strike_clr_o,
    output logic              out_valid_o,
    output logic              busy_o
);
    typedef enum logic [1:0] {INIT, CLEAR, RUN, DRAIN} state_t;
    state_t     state;
    logic [1:0] ph;
    logic [7:0] v, v_nxt;
    logic       active, acc, last;
    assign active       = state == RUN || state == DRAIN;
    assign req_ready_o  = state == RUN && ph == 2'd0 && !clear_i;
    assign acc          = req_valid_i & req_ready_o;
    assign last         = clr_addr_o == ADDR_W'(NUM_STRIPS - 1);
    assign phase_en_o   = active ? 4'(4'b0001 << ph) : 4'b0000;
    assign ram_rd_en_o  = active && ph == 2'd2 && v[1];
    assign clr_active_o = state == CLEAR;
    assign ram_wr_en_o  = clr_active_o || (active && ph == 2'd1 && v[4]);
    assign strike_clr_o = clr_active_o && clr_addr_o == '0;
    assign out_valid_o  = v[7];
    assign busy_o       = state != RUN || |v;
    // A token moves into the two stages owning the current phase and leaves its old slot,
    // so each token occupies exactly one bit and v empties as soon as the O stage is done.
    always_comb begin
        v_nxt = v;
        if (active)
            for (int s = 0; s < 8; s++)
                if (s % 4 == int'(ph)) begin
                    v_nxt[s]           = (s == 0) ? acc : v[(s + 7) % 8];
                    v_nxt[(s + 7) % 8] = 1'b0;
                end
    end
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= INIT;
            ph         <= 2'd0;
            v          <= '0;
            clr_addr_o <= '0;
        end else begin
            v  <= v_nxt;
            ph <= active ? ph + 2'd1 : 2'd0;
            case (state)
                INIT:  state <= CLEAR;
                CLEAR: begin
                    clr_addr_o <= last ? '0 : clr_addr_o + 1'b1;
                    if (last) state <= RUN;
                end
                RUN:   if (clear_i) state <= DRAIN;
                DRAIN: if (v_nxt == '0) state <= CLEAR;
                default: state <= INIT;
            endcase
        end
    end
endmodule
